// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM states, default widths
// and the word-count encoding where a count byte of zero stands for 256 words.
package loader_pkg;

  localparam int ADDR_W = 8;
  localparam int INST_W = 16;
  localparam int BYTE_W = 8;

  // The remaining-word counter is one bit wider than the address so it can hold 256.
  localparam logic [8:0] COUNT_ZERO_MEANS_256 = 9'd256;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    HI,
    LO,
    WRITE,
    CSUM,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream handshake plus instruction-memory write bus of the program loader.
// The master modport is the loader itself; slave is the stream source and memory side.
interface program_loader_if #(
  parameter int ADDR_W = loader_pkg::ADDR_W,
  parameter int INST_W = loader_pkg::INST_W,
  parameter int BYTE_W = loader_pkg::BYTE_W
);

  logic [BYTE_W-1:0] byte_data;
  logic              byte_valid;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_wdata;

  modport master (
    input  byte_data, byte_valid,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output byte_data, byte_valid,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/program_loader.sv
// Loads a checksummed byte stream into instruction memory as 16-bit words and
// holds the processor in reset until a load completes with a matching XOR checksum.
module program_loader #(
  parameter int ADDR_W = loader_pkg::ADDR_W,
  parameter int INST_W = loader_pkg::INST_W,
  parameter int BYTE_W = loader_pkg::BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  program_loader_if.master  bus,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  import loader_pkg::*;

  localparam int CNT_W = ADDR_W + 1;

  state_t            state;
  logic [BYTE_W-1:0] hi_byte;
  logic [BYTE_W-1:0] acc;
  logic [CNT_W-1:0]  remaining;
  logic              xfer;

  assign xfer = bus.byte_valid && bus.byte_ready;

  // NOTE: all state and outputs update with non-blocking assignments so every
  // branch below reads the pre-edge values, exactly as the registers hold them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cpu_rst        <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      bus.byte_ready <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      hi_byte        <= '0;
      acc            <= '0;
      remaining      <= '0;
    end else begin
      case (state)
        // A start from a finished load behaves exactly like a start from idle.
        IDLE, DONE, ERR: begin
          if (start) begin
            state          <= COUNT;
            busy           <= 1'b1;
            done           <= 1'b0;
            err            <= 1'b0;
            cpu_rst        <= 1'b1;
            bus.byte_ready <= 1'b1;
            bus.imem_addr  <= '0;
            acc            <= '0;
            remaining      <= '0;
          end
        end

        COUNT: begin
          if (xfer) begin
            remaining <= (bus.byte_data == '0) ? COUNT_ZERO_MEANS_256
                                               : CNT_W'(bus.byte_data);
            state     <= HI;
          end
        end

        HI: begin
          if (xfer) begin
            hi_byte <= bus.byte_data;
            acc     <= acc ^ bus.byte_data;
            state   <= LO;
          end
        end

        LO: begin
          if (xfer) begin
            acc            <= acc ^ bus.byte_data;
            bus.imem_wdata <= INST_W'({hi_byte, bus.byte_data});
            bus.imem_we    <= 1'b1;
            bus.byte_ready <= 1'b0;
            state          <= WRITE;
          end
        end

        // The address only advances when another word follows, so it never wraps.
        WRITE: begin
          bus.imem_we    <= 1'b0;
          bus.byte_ready <= 1'b1;
          remaining      <= remaining - 1'b1;
          if (remaining == CNT_W'(1)) begin
            state <= CSUM;
          end else begin
            bus.imem_addr <= bus.imem_addr + 1'b1;
            state         <= HI;
          end
        end

        CSUM: begin
          if (xfer) begin
            bus.byte_ready <= 1'b0;
            busy           <= 1'b0;
            if (bus.byte_data == acc) begin
              done    <= 1'b1;
              cpu_rst <= 1'b0;
              state   <= DONE;
            end else begin
              err     <= 1'b1;
              cpu_rst <= 1'b1;
              state   <= ERR;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Sits upstream of the processor's instruction memory and feeds it.
- Accepts a byte stream over a valid/ready handshake and assembles 16-bit instruction words ({op, rs, rt, rd}).
- Writes each word into instruction memory at consecutive 8-bit addresses from 0.
- Holds the processor in reset until a load completes with a correct XOR checksum.

Parameters:
- ADDR_W, 8: instruction address width; matches the PC width.
- INST_W, 16: instruction word width.
- BYTE_W, 8: input stream byte width.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset: synchronous, active-high.
- start  input  1  one-cycle pulse that begins a load.
- byte_data  input  8  stream byte.
- byte_valid  input  1  byte_data is valid.
- byte_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction memory write strobe.
- imem_addr  output  8  instruction memory write address.
- imem_wdata  output  16  instruction word to write.
- cpu_rst  output  1  reset to the processor (drives its rst).
- busy  output  1  load in progress.
- done  output  1  last load succeeded.
- err  output  1  last load failed its checksum.

Behaviour:
- Clock and reset:
  - One clock domain. Reset is synchronous and active-high.
  - All outputs are registered.
- Reset values:
  - cpu_rst=1.
  - busy=0, done=0, err=0.
  - byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - State=IDLE.
- Byte transfer rule:
  - A byte transfers on a cycle where byte_valid && byte_ready.
  - byte_data must be sampled only on that cycle.
- Stream format:
  - Byte 0 is the word count N. N=0 means 256.
  - Then N words follow, each as two bytes, high byte first.
  - Then one checksum byte: the XOR of all 2N data bytes. The count byte is excluded.
- States:
  - IDLE: byte_ready=0. On start go to COUNT. Set busy=1, done=0, err=0, cpu_rst=1. Clear the address, XOR accumulator and remaining counter.
  - COUNT: byte_ready=1. On transfer, latch N into a 9-bit remaining counter (0 becomes 256). Go to HI.
  - HI: byte_ready=1. On transfer, latch the high byte and XOR it into the accumulator. Go to LO.
  - LO: byte_ready=1. On transfer, latch the low byte, XOR it, and load imem_wdata. Go to WRITE.
  - WRITE: byte_ready=0. imem_we=1 for exactly one cycle with the current imem_addr and imem_wdata. Decrement remaining. If remaining becomes 0, go to CSUM; otherwise increment imem_addr and go to HI.
  - CSUM: byte_ready=1. On transfer, compare the byte with the accumulator. Match: go to DONE with done=1, busy=0, cpu_rst=0. Mismatch: go to ERR with err=1, busy=0, cpu_rst=1.
  - DONE and ERR: byte_ready=0. Hold outputs. A start pulse re-enters the IDLE actions in the same cycle: busy=1, cpu_rst=1, flags cleared, next state COUNT.
- Latency: from LO acceptance, imem_we is high on the next cycle.
  - Peak throughput is one word per 3 cycles with byte_valid held high.
- Address rule:
  - imem_addr is never incremented past the final write.
  - For N=256 the last write is at 255 and imem_addr stays 255.
  - No 8-bit wrap-around occurs.
- Ignored start: start during COUNT/HI/LO/WRITE/CSUM is ignored. The load continues undisturbed.
- Stalls: byte_valid low for any number of cycles stalls the FSM. No timeout.
- Reset mid-load: rst forces the reset values on the next edge.
  - Partial memory contents are left as written. cpu_rst stays 1.
- Outputs in IDLE:
  - imem_wdata and imem_addr hold their last values; they are meaningful only while imem_we=1.
  - imem_we is 0 in every state except WRITE.

Decomposition:
- Shared package loader_pkg holds:
  - the state enum (IDLE, COUNT, HI, LO, WRITE, CSUM, DONE, ERR);
  - the ADDR_W, INST_W and BYTE_W default constants;
  - the COUNT_ZERO_MEANS_256 constant (9'd256).
- The design is flat and has no sub-module. The FSM, XOR accumulator and counters are tightly coupled.

Test Plan:
- Basic load: start, then stream 02,12,34,AB,CD, csum 12^34^AB^CD=40.
  - imem_we pulses at addr 0 with 1234, then at addr 1 with ABCD.
  - Then done=1, cpu_rst=0, busy=0.
- Bad checksum: the same stream with csum 41.
  - Both writes occur, then err=1, done=0, cpu_rst stays 1.
- Throttled source: byte_valid toggles 1,0,0,1 through the basic load.
  - Writes and result are identical to the basic load.
  - byte_ready=0 in every WRITE cycle.
- N=0 (256 words): 512 data bytes of pattern addr, ~addr.
  - The last write is at addr FF with wdata FF00.
  - imem_addr holds FF and done=1 with the correct checksum.
- Reset and restart: assert rst during HI of the 2nd word.
  - All outputs take reset values the next cycle.
  - A new start plus a full stream loads correctly from addr 0.
- Start while busy and reload from DONE:
  - start pulses during LO are ignored.
  - start in DONE reasserts cpu_rst=1 and busy=1 and a second load succeeds.
